// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: default width and FSM state encoding.
package countdown_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_decrementer.sv
// WIDTH-bit ripple-borrow A-1, the subtracting twin of the game's ripple adder.
module countdown_timer_decrementer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    logic borrow;

    // Borrow enters at bit 0 and ripples up through every zero bit.
    always_comb begin
        borrow = 1'b1;
        y      = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            y[i]   = a[i] ^ borrow;
            borrow = borrow & ~a[i];
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause and optional auto-reload; pulses tick for one cycle on expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             zero,
    output logic             running,
    output logic             paused
);

    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] period, period_nxt;
    logic [WIDTH-1:0] count_nxt, count_dec;
    logic             tick_nxt;

    countdown_timer_decrementer #(.WIDTH(WIDTH)) u_dec (
        .a (count),
        .y (count_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            period <= '0;
            tick   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            period <= period_nxt;
            tick   <= tick_nxt;
        end
    end

    // Priority: clear, then load, then normal counting; the period survives a clear.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        period_nxt = period;
        tick_nxt   = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
        end else if (load) begin
            count_nxt  = load_value;
            period_nxt = load_value;
            if (load_value == '0) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = enable ? ST_RUN : ST_PAUSED;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_nxt = ST_PAUSED;
                    end else if (count == COUNT_ONE) begin
                        tick_nxt = 1'b1;
                        if (AUTO_RELOAD) begin
                            count_nxt = period;
                        end else begin
                            count_nxt = '0;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        count_nxt = count_dec;
                    end
                end
                ST_PAUSED: begin
                    if (enable) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign zero    = (count == '0);
    assign running = (state == ST_RUN);
    assign paused  = (state == ST_PAUSED);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one-shot and auto-reload instances against a behavioural model.
module tb_countdown_timer;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;

    logic [W-1:0] count_os, count_ar;
    logic         tick_os, tick_ar, zero_os, zero_ar;
    logic         running_os, running_ar, paused_os, paused_ar;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index 0 = one-shot instance, index 1 = auto-reload instance.
    // mode: 0 idle, 1 counting, 2 paused.
    int m_count[2];
    int m_period[2];
    int m_mode[2];
    int m_tick[2];

    typedef struct {
        logic       clr;
        logic       ld;
        logic [4:0] lv;
        logic       en;
        int         exp_count;
        int         exp_tick;
        int         exp_run;
        int         exp_pause;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_os (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable),
        .count(count_os), .tick(tick_os), .zero(zero_os),
        .running(running_os), .paused(paused_os)
    );

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_ar (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable),
        .count(count_ar), .tick(tick_ar), .zero(zero_ar),
        .running(running_ar), .paused(paused_ar)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0; m_period[i] = 0; m_mode[i] = 0; m_tick[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 0;
            if (clear) begin
                m_count[i] = 0;
                m_mode[i]  = 0;
            end else if (load) begin
                m_count[i]  = int'(load_value);
                m_period[i] = int'(load_value);
                m_mode[i]   = (load_value == 0) ? 0 : (enable ? 1 : 2);
            end else if (m_mode[i] == 1) begin
                if (!enable) m_mode[i] = 2;
                else if (m_count[i] == 1) begin
                    m_tick[i] = 1;
                    if (i == 1) m_count[i] = m_period[i];
                    else begin
                        m_count[i] = 0;
                        m_mode[i]  = 0;
                    end
                end else m_count[i] = (m_count[i] + 31) % 32;
            end else if (m_mode[i] == 2 && enable) begin
                m_mode[i] = 1;
            end
        end
    endfunction

    task automatic check_all();
        check("os_count",   int'(count_os),   m_count[0]);
        check("os_tick",    int'(tick_os),    m_tick[0]);
        check("os_zero",    int'(zero_os),    int'(m_count[0] == 0));
        check("os_running", int'(running_os), int'(m_mode[0] == 1));
        check("os_paused",  int'(paused_os),  int'(m_mode[0] == 2));
        check("ar_count",   int'(count_ar),   m_count[1]);
        check("ar_tick",    int'(tick_ar),    m_tick[1]);
        check("ar_zero",    int'(zero_ar),    int'(m_count[1] == 0));
        check("ar_running", int'(running_ar), int'(m_mode[1] == 1));
        check("ar_paused",  int'(paused_ar),  int'(m_mode[1] == 2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic c, input logic l, input logic [W-1:0] v, input logic e);
        clear = c; load = l; load_value = v; enable = e;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 5'd3, 1'b1, 3, 0, 1, 0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 1'b1, 2, 0, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1, 0, 1, 0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 1'b1, 0, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 1'b0, 0, 0, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 5'd2, 1'b0, 2, 0, 0, 1};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 1'b0, 2, 0, 0, 1};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 1'b1, 2, 0, 1, 0};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1, 0, 1, 0};
        vecs[10] = '{1'b1, 1'b0, 5'd0, 1'b1, 0, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 5'd0, 1'b1, 0, 0, 0, 0};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Table: one-shot load 3 and assorted idle/pause/clear/load-0 cases
        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].clr, vecs[k].ld, vecs[k].lv, vecs[k].en);
            step();
            check($sformatf("vec%0d_count", k),   int'(count_os),   vecs[k].exp_count);
            check($sformatf("vec%0d_tick", k),    int'(tick_os),    vecs[k].exp_tick);
            check($sformatf("vec%0d_running", k), int'(running_os), vecs[k].exp_run);
            check($sformatf("vec%0d_paused", k),  int'(paused_os),  vecs[k].exp_pause);
        end

        // Auto-reload period 4: three full periods
        drive(1'b0, 1'b1, 5'd4, 1'b1);
        step();
        check("ar_load4", int'(count_ar), 4);
        drive(1'b0, 1'b0, 5'd0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("ar_seq%0d_count", k), int'(count_ar), 4 - (k % 4));
            check($sformatf("ar_seq%0d_tick", k),  int'(tick_ar),  int'(k % 4 == 0));
        end

        // Pause at 5 for three cycles, then one hold edge, then 4,3
        drive(1'b0, 1'b1, 5'd5, 1'b1);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("pause_count", int'(count_os), 5);
            check("pause_flag",  int'(paused_os), 1);
        end
        drive(1'b0, 1'b0, 5'd0, 1'b1);
        step();
        check("resume_hold", int'(count_os), 5);
        check("resume_running", int'(running_os), 1);
        step();
        check("resume_dec1", int'(count_os), 4);
        step();
        check("resume_dec2", int'(count_os), 3);

        // Load 9 on the terminal cycle: no tick, new value, running
        drive(1'b0, 1'b1, 5'd2, 1'b1);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b1);
        step();
        check("term_pre_count", int'(count_ar), 1);
        drive(1'b0, 1'b1, 5'd9, 1'b1);
        step();
        check("term_load_count", int'(count_ar), 9);
        check("term_load_tick",  int'(tick_ar), 0);
        check("term_load_os_tick", int'(tick_os), 0);
        check("term_load_run",   int'(running_ar), 1);

        // Clear together with load at count 6
        drive(1'b0, 1'b1, 5'd6, 1'b0);
        step();
        drive(1'b1, 1'b1, 5'd6, 1'b1);
        step();
        check("clrld_count", int'(count_ar), 0);
        check("clrld_idle",  int'(running_ar | paused_ar), 0);
        drive(1'b0, 1'b1, 5'd0, 1'b1);
        step();
        check("load0_tick", int'(tick_ar), 0);
        check("load0_zero", int'(zero_ar), 1);

        // Asynchronous reset mid-count at 7
        drive(1'b0, 1'b1, 5'd7, 1'b1);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b1);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_count",   int'(count_ar), 0);
        check("arst_tick",    int'(tick_ar), 0);
        check("arst_zero",    int'(zero_ar), 1);
        check("arst_running", int'(running_ar), 0);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0),
                  W'($urandom), 1'($urandom_range(0, 3) != 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
